// File: rtl/counter_stim_gen.sv
// Stimulus generator and self-checker for an 8-bit inc/dec counter.
// Drives inc/dec per mode, models the expected count, and counts mismatches.
module counter_stim_gen #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = 16,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [LEN_W-1:0] len,
    input  logic [WIDTH-1:0] cnt,
    output logic             inc,
    output logic             dec,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [LEN_W-1:0] err_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SYNC  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] M_INC  = 2'b00;
    localparam logic [1:0] M_DEC  = 2'b01;
    localparam logic [1:0] M_HOLD = 2'b10;
    localparam logic [1:0] M_RAND = 2'b11;

    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] ERR_MAX = {LEN_W{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]       state;
    logic [2:0]       state_d;
    logic [1:0]       mode_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] run_q;
    logic [15:0]      lfsr;
    logic [15:0]      lfsr_nx;
    logic [WIDTH-1:0] exp_q;
    logic             drv_inc;
    logic             drv_dec;
    logic             last_run;
    logic             cmp_en;
    logic             fail;
    logic             accept;

    // Taps 16,14,13,11, shifting towards bit 0.
    assign lfsr_nx  = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    assign last_run = (run_q == (len_q - LEN_ONE));
    assign accept   = (state == S_IDLE) && start;
    assign cmp_en   = (state == S_RUN) || (state == S_DRAIN);
    assign fail     = cmp_en && (cnt != exp_q);

    assign busy = (state == S_SYNC) || (state == S_RUN) ||
                  (state == S_DRAIN);
    assign done = (state == S_DONE);

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (start) state_d = S_SYNC;
            S_SYNC:  state_d = (len_q != '0) ? S_RUN : S_DRAIN;
            S_RUN:   if (last_run) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        drv_inc = 1'b0;
        drv_dec = 1'b0;
        case (mode_q)
            M_INC:  drv_inc = 1'b1;
            M_DEC:  drv_dec = 1'b1;
            M_HOLD: ;
            M_RAND: begin
                drv_inc = lfsr[0] & ~lfsr[1];
                drv_dec = lfsr[1] & ~lfsr[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            mode_q   <= M_INC;
            len_q    <= '0;
            run_q    <= '0;
            lfsr     <= SEED;
            exp_q    <= '0;
            inc      <= 1'b0;
            dec      <= 1'b0;
            mismatch <= 1'b0;
            err_cnt  <= '0;
        end else begin
            state    <= state_d;
            mismatch <= fail;

            if (accept) begin
                mode_q <= mode;
                len_q  <= len;
                run_q  <= '0;
                lfsr   <= SEED;
            end

            if (state == S_SYNC) begin
                exp_q <= cnt;
            end

            // The model follows the drive that was on the wires this cycle.
            if (state == S_RUN) begin
                run_q <= run_q + LEN_ONE;
                if (inc) begin
                    exp_q <= exp_q + CNT_ONE;
                end else if (dec) begin
                    exp_q <= exp_q - CNT_ONE;
                end
            end

            if (accept) begin
                err_cnt <= '0;
            end else if (fail && (err_cnt != ERR_MAX)) begin
                err_cnt <= err_cnt + LEN_ONE;
            end

            // Drive is registered one edge ahead of the RUN cycle it covers.
            if (state_d == S_RUN) begin
                inc  <= drv_inc;
                dec  <= drv_dec;
                lfsr <= lfsr_nx;
            end else begin
                inc <= 1'b0;
                dec <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_counter_stim_gen.sv
// Bench for counter_stim_gen: behavioural counter beside the DUT,
// table-driven runs plus reset and busy-start corner sequences.
module tb_counter_stim_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] len;
    logic [7:0]  cnt;
    logic        inc;
    logic        dec;
    logic        busy;
    logic        done;
    logic        mismatch;
    logic [15:0] err_cnt;

    logic        ld;
    logic        stuck;
    logic [7:0]  ld_val;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] mode;
        int         len;
        logic [7:0] init;
        bit         stuck;
        bit         use_model;
        bit         poke;
        logic [7:0] fin;
        int         err;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    // Ideal (or stuck) counter: drive at edge t shows in cycle t+1.
    always_ff @(posedge clk) begin
        if (ld) begin
            cnt <= ld_val;
        end else if (!stuck) begin
            if (inc) cnt <= cnt + 8'd1;
            else if (dec) cnt <= cnt - 8'd1;
        end
    end

    counter_stim_gen #(
        .WIDTH(8),
        .LEN_W(16),
        .SEED(16'hACE1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .mode(mode),
        .len(len),
        .cnt(cnt),
        .inc(inc),
        .dec(dec),
        .busy(busy),
        .done(done),
        .mismatch(mismatch),
        .err_cnt(err_cnt)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        logic fb;
        fb = x[0] ^ x[2] ^ x[3] ^ x[5];
        return (x >> 1) | (16'(fb) << 15);
    endfunction

    task automatic chk(input string name, input longint act,
                       input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag,
                           output int sig);
        logic [15:0] m;
        logic [7:0]  model_cnt;
        logic        e_i;
        logic        e_d;
        bit          in_run;
        int done_n = 0, done_cyc = -1, mis_n = 0, last_mis = -1;
        int both = 0, win_err = 0, busy_err = 0, seq_err = 0;
        sig = 0;
        m = 16'hACE1;
        model_cnt = v.init;
        @(negedge clk);
        stuck = v.stuck;
        ld = 1'b1;
        ld_val = v.init;
        @(negedge clk);
        ld = 1'b0;
        start = 1'b1;
        mode = v.mode;
        len = 16'(v.len);
        for (int cyc = 1; cyc <= v.len + 20; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start = v.poke;
                mode = ~v.mode;
                len = 16'd7;
            end
            if (cyc == 2) start = 1'b0;
            in_run = (cyc >= 2) && (cyc <= v.len + 1);
            if ((inc || dec) && !in_run) win_err++;
            if (inc && dec) both++;
            if (busy != ((cyc >= 1) && (cyc <= v.len + 2))) busy_err++;
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
            if (mismatch) begin
                mis_n++;
                last_mis = cyc;
            end
            if (in_run) begin
                e_i = (v.mode == 2'b00) ||
                      (v.mode == 2'b11 && m[0] && !m[1]);
                e_d = (v.mode == 2'b01) ||
                      (v.mode == 2'b11 && m[1] && !m[0]);
                if (inc !== e_i || dec !== e_d) seq_err++;
                if (e_i) model_cnt = model_cnt + 8'd1;
                if (e_d) model_cnt = model_cnt - 8'd1;
                m = lfsr_step(m);
                sig = sig * 31 + int'({inc, dec}) + 1;
            end
            if (cyc == v.len + 4) break;
        end
        chk({tag, " done_cycle"}, done_cyc, v.len + 3);
        chk({tag, " done_pulses"}, done_n, 1);
        chk({tag, " err_cnt"}, err_cnt, v.err);
        chk({tag, " mismatch_pulses"}, mis_n, v.err);
        chk({tag, " inc_dec_both"}, both, 0);
        chk({tag, " drive_outside_run"}, win_err, 0);
        chk({tag, " busy_window"}, busy_err, 0);
        chk({tag, " drive_sequence"}, seq_err, 0);
        chk({tag, " final_cnt"}, cnt,
            v.use_model ? model_cnt : v.fin);
        if (v.err > 0) chk({tag, " last_mismatch_cycle"}, last_mis,
                           v.len + 3);
    endtask

    int sig_a, sig_b, sig_x;
    int dn;

    initial begin
        //          mode   len   init   stk mdl pok fin    err
        vecs[0] = '{2'b00, 10,   8'hFA, 0,  0,  0,  8'h04, 0};
        vecs[1] = '{2'b01, 5,    8'h02, 0,  0,  0,  8'hFD, 0};
        vecs[2] = '{2'b10, 3,    8'h55, 0,  0,  0,  8'h55, 0};
        vecs[3] = '{2'b00, 4,    8'h00, 1,  0,  0,  8'h00, 4};
        vecs[4] = '{2'b11, 0,    8'h10, 0,  0,  1,  8'h10, 0};
        vecs[5] = '{2'b01, 2,    8'h7F, 1,  0,  0,  8'h7F, 2};
        vecs[6] = '{2'b00, 1,    8'hFF, 0,  0,  1,  8'h00, 0};
        vecs[7] = '{2'b11, 1000, 8'h80, 0,  1,  0,  8'h00, 0};

        rst = 1'b1;
        start = 1'b1;
        mode = 2'b00;
        len = 16'd3;
        ld = 1'b1;
        ld_val = 8'h00;
        stuck = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset inc", inc, 0);
        chk("reset dec", dec, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset mismatch", mismatch, 0);
        chk("reset err_cnt", err_cnt, 0);
        rst = 1'b0;
        start = 1'b0;
        ld = 1'b0;
        @(negedge clk);
        chk("idle after reset busy", busy, 0);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i), sig_x);
            if (i == 7) sig_a = sig_x;
        end
        run_vec(vecs[7], "vec7_repeat", sig_b);
        chk("random repeat signature", sig_b, sig_a);

        // Reset in cycle 5 of a len=20 run.
        dn = 0;
        @(negedge clk);
        stuck = 1'b0;
        ld = 1'b1;
        ld_val = 8'h00;
        @(negedge clk);
        ld = 1'b0;
        start = 1'b1;
        mode = 2'b00;
        len = 16'd20;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (done) dn++;
        end
        chk("midrun busy before reset", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrun reset inc", inc, 0);
        chk("midrun reset dec", dec, 0);
        chk("midrun reset busy", busy, 0);
        chk("midrun reset done", done, 0);
        chk("midrun reset mismatch", mismatch, 0);
        chk("midrun reset err_cnt", err_cnt, 0);
        rst = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (done || busy || inc || dec) dn++;
        end
        chk("no activity after midrun reset", dn, 0);
        run_vec(vecs[0], "after_reset", sig_x);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
